// File: rtl/dec_counter_ctl.sv
// dec_counter_ctl: registered, loadable down-counter with terminal-count and borrow flags.
// Counts down by STEP from a loaded start value. It either saturates at zero (WRAP=0)
// or wraps modulo 2**WIDTH (WRAP=1).
// Optional feature macro: DEC_COUNTER_AUTO_RELOAD_EN. When it is defined, DONE reloads
// the last loaded value and the counter restarts on its own.
module dec_counter_ctl #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned STEP  = 1,
    parameter int unsigned WRAP  = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             zero,
    output logic             done,
    output logic             underflow
);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_t;

    localparam logic [WIDTH:0] StepExt = (WIDTH + 1)'(STEP);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic             underflow_q, underflow_d;
    logic [WIDTH:0]   diff;
    logic             borrow;

    // The borrow is the top bit of a one-bit-wider unsigned subtract.
    assign diff   = {1'b0, count_q} - StepExt;
    assign borrow = diff[WIDTH];

`ifdef DEC_COUNTER_AUTO_RELOAD_EN
    logic [WIDTH-1:0] reload_q, reload_d;

    // Reload register: holds the most recently accepted load value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            reload_q <= '0;
        end else begin
            reload_q <= reload_d;
        end
    end
`endif

    // Next-state logic: load takes priority over every other transition.
    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        underflow_d = 1'b0;
`ifdef DEC_COUNTER_AUTO_RELOAD_EN
        reload_d    = reload_q;
`endif
        if (load) begin
            count_d = load_val;
            state_d = (load_val != '0) ? StRun : StDone;
`ifdef DEC_COUNTER_AUTO_RELOAD_EN
            reload_d = load_val;
`endif
        end else begin
            case (state_q)
                StIdle: ;
                StRun: begin
                    if (enable) begin
                        if (borrow) begin
                            if (WRAP != 0) begin
                                count_d     = diff[WIDTH-1:0];
                                underflow_d = 1'b1;
                            end else begin
                                count_d = '0;
                                state_d = StDone;
                            end
                        end else if (diff[WIDTH-1:0] == '0) begin
                            count_d = '0;
                            state_d = StDone;
                        end else begin
                            count_d = diff[WIDTH-1:0];
                        end
                    end
                end
                StDone: begin
`ifdef DEC_COUNTER_AUTO_RELOAD_EN
                    count_d = reload_q;
                    state_d = (reload_q != '0) ? StRun : StDone;
`else
                    state_d = StIdle;
`endif
                end
                default: state_d = StIdle;
            endcase
        end
    end

    // State, count and underflow registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            count_q     <= '0;
            underflow_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            underflow_q <= underflow_d;
        end
    end

    assign count     = count_q;
    assign busy      = (state_q == StRun);
    assign done      = (state_q == StDone);
    assign zero      = (count_q == '0);
    assign underflow = (WRAP != 0) ? underflow_q : 1'b0;

endmodule

// File: tb/tb_dec_counter_ctl.sv
// Directed self-checking bench for dec_counter_ctl.
// Three instances share one stimulus: a (STEP=1, saturate), b (STEP=3, saturate),
// c (STEP=3, wrap). Each check packs {count, busy, zero, done, underflow} into one vector.
module tb_dec_counter_ctl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       enable;
    logic       load;
    logic [3:0] load_val;

    logic [3:0] cnt_a, cnt_b, cnt_c;
    logic       busy_a, busy_b, busy_c;
    logic       zero_a, zero_b, zero_c;
    logic       done_a, done_b, done_c;
    logic       unf_a, unf_b, unf_c;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dec_counter_ctl #(.WIDTH(4), .STEP(1), .WRAP(0)) u_a (
        .clk(clk), .rst_n(rst_n), .enable(enable), .load(load), .load_val(load_val),
        .count(cnt_a), .busy(busy_a), .zero(zero_a), .done(done_a), .underflow(unf_a)
    );
    dec_counter_ctl #(.WIDTH(4), .STEP(3), .WRAP(0)) u_b (
        .clk(clk), .rst_n(rst_n), .enable(enable), .load(load), .load_val(load_val),
        .count(cnt_b), .busy(busy_b), .zero(zero_b), .done(done_b), .underflow(unf_b)
    );
    dec_counter_ctl #(.WIDTH(4), .STEP(3), .WRAP(1)) u_c (
        .clk(clk), .rst_n(rst_n), .enable(enable), .load(load), .load_val(load_val),
        .count(cnt_c), .busy(busy_c), .zero(zero_c), .done(done_c), .underflow(unf_c)
    );

    wire [7:0] obs_a = {cnt_a, busy_a, zero_a, done_a, unf_a};
    wire [7:0] obs_b = {cnt_b, busy_b, zero_b, done_b, unf_b};
    wire [7:0] obs_c = {cnt_c, busy_c, zero_c, done_c, unf_c};

    // Sample one time unit after the rising edge, away from the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; enable = 1'b0; load = 1'b0; load_val = 4'd0;
        tick(); tick();
        checks++;
        if (obs_a !== 8'b0000_0100) begin
            errors++; $display("FAIL reset_a got %b want %b", obs_a, 8'b0000_0100);
        end
        checks++;
        if (obs_c !== 8'b0000_0100) begin
            errors++; $display("FAIL reset_c got %b want %b", obs_c, 8'b0000_0100);
        end
        #2 rst_n = 1'b1;
        tick();
        checks++;
        if (obs_a !== 8'b0000_0100) begin
            errors++; $display("FAIL idle_after_reset got %b want %b", obs_a, 8'b0000_0100);
        end
    endtask

    // Load 5, enable held high: 5,4,3,2,1,0+done, then idle.
    task automatic test_count_down();
        logic [3:0] exp_cnt [7] = '{4'd5, 4'd4, 4'd3, 4'd2, 4'd1, 4'd0, 4'd0};
        logic       exp_bsy [7] = '{1, 1, 1, 1, 1, 0, 0};
        logic       exp_dn  [7] = '{0, 0, 0, 0, 0, 1, 0};
        logic [7:0] exp;
        load = 1'b1; load_val = 4'd5; enable = 1'b1;
        for (int i = 0; i < 7; i++) begin
            tick();
            load = 1'b0;
            exp = {exp_cnt[i], exp_bsy[i], exp_cnt[i] == 4'd0, exp_dn[i], 1'b0};
            checks++;
            if (obs_a !== exp) begin
                errors++; $display("FAIL count_down[%0d] got %b want %b", i, obs_a, exp);
            end
        end
        enable = 1'b0;
    endtask

    // Load 3, enable 1,0,1,1: 3,2,2,1,0.
    task automatic test_enable_gate();
        logic       en_seq  [5] = '{0, 1, 0, 1, 1};
        logic [3:0] exp_cnt [5] = '{4'd3, 4'd2, 4'd2, 4'd1, 4'd0};
        logic [7:0] exp;
        load = 1'b1; load_val = 4'd3;
        for (int i = 0; i < 5; i++) begin
            enable = en_seq[i];
            tick();
            load = 1'b0;
            exp = {exp_cnt[i], i < 4, exp_cnt[i] == 4'd0, i == 4, 1'b0};
            checks++;
            if (obs_a !== exp) begin
                errors++; $display("FAIL enable_gate[%0d] got %b want %b", i, obs_a, exp);
            end
        end
        enable = 1'b0;
        tick();
    endtask

    // STEP=3 from 7: saturate gives 7,4,1,0+done; wrap gives 7,4,1,14+underflow,11.
    task automatic test_step_modes();
        logic [7:0] exp_b [5] = '{8'b0111_1000, 8'b0100_1000, 8'b0001_1000,
                                  8'b0000_0110, 8'b0000_0100};
        logic [7:0] exp_c [5] = '{8'b0111_1000, 8'b0100_1000, 8'b0001_1000,
                                  8'b1110_1001, 8'b1011_1000};
        load = 1'b1; load_val = 4'd7; enable = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            load = 1'b0;
            checks++;
            if (obs_b !== exp_b[i]) begin
                errors++; $display("FAIL saturate[%0d] got %b want %b", i, obs_b, exp_b[i]);
            end
            checks++;
            if (obs_c !== exp_c[i]) begin
                errors++; $display("FAIL wrap[%0d] got %b want %b", i, obs_c, exp_c[i]);
            end
        end
        enable = 1'b0;
    endtask

    // Load 0: done next cycle with busy never set; a reload mid-run restarts without done.
    task automatic test_load_cases();
        load = 1'b1; load_val = 4'd0; enable = 1'b0;
        tick();
        load = 1'b0;
        checks++;
        if (obs_a !== 8'b0000_0110) begin
            errors++; $display("FAIL load_zero_done got %b want %b", obs_a, 8'b0000_0110);
        end
        tick();
        checks++;
        if (obs_a !== 8'b0000_0100) begin
            errors++; $display("FAIL load_zero_idle got %b want %b", obs_a, 8'b0000_0100);
        end
        load = 1'b1; load_val = 4'd5; enable = 1'b1;
        tick();
        load = 1'b0;
        tick(); tick(); tick();
        checks++;
        if (obs_a !== 8'b0010_1000) begin
            errors++; $display("FAIL pre_reload got %b want %b", obs_a, 8'b0010_1000);
        end
        load = 1'b1; load_val = 4'd9;
        tick();
        load = 1'b0;
        checks++;
        if (obs_a !== 8'b1001_1000) begin
            errors++; $display("FAIL reload_mid_run got %b want %b", obs_a, 8'b1001_1000);
        end
        enable = 1'b0;
    endtask

    // Load in the DONE cycle overrides DONE->IDLE.
    task automatic test_back_to_back();
        load = 1'b1; load_val = 4'd1; enable = 1'b1;
        tick();
        load = 1'b0;
        tick();
        checks++;
        if (obs_a !== 8'b0000_0110) begin
            errors++; $display("FAIL b2b_done got %b want %b", obs_a, 8'b0000_0110);
        end
        load = 1'b1; load_val = 4'd3;
        tick();
        load = 1'b0;
        checks++;
        if (obs_a !== 8'b0011_1000) begin
            errors++; $display("FAIL b2b_reload got %b want %b", obs_a, 8'b0011_1000);
        end
        enable = 1'b0;
    endtask

    // Asserting reset between edges clears the count at once, and no done follows.
    task automatic test_async_reset();
        load = 1'b1; load_val = 4'd6; enable = 1'b1;
        tick();
        load = 1'b0;
        tick();
        #3 rst_n = 1'b0;
        #1;
        checks++;
        if (obs_a !== 8'b0000_0100) begin
            errors++; $display("FAIL async_reset got %b want %b", obs_a, 8'b0000_0100);
        end
        tick();
        #2 rst_n = 1'b1;
        tick();
        checks++;
        if (obs_a !== 8'b0000_0100) begin
            errors++; $display("FAIL post_reset_no_done got %b want %b", obs_a, 8'b0000_0100);
        end
        enable = 1'b0;
    endtask

`ifdef DEC_COUNTER_AUTO_RELOAD_EN
    // Load 2 repeats 2,1,0+done,2,...; a load of 4 mid-run replaces the reload value.
    task automatic test_auto_reload();
        logic [3:0] exp_cnt [10] = '{4'd2, 4'd1, 4'd0, 4'd2, 4'd4, 4'd3, 4'd2, 4'd1, 4'd0, 4'd4};
        logic [7:0] exp;
        load = 1'b1; load_val = 4'd2; enable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            load = (i == 0) || (i == 4);
            load_val = (i == 4) ? 4'd4 : 4'd2;
            tick();
            exp = {exp_cnt[i], exp_cnt[i] != 4'd0, exp_cnt[i] == 4'd0, exp_cnt[i] == 4'd0, 1'b0};
            checks++;
            if (obs_a !== exp) begin
                errors++; $display("FAIL auto_reload[%0d] got %b want %b", i, obs_a, exp);
            end
        end
        load = 1'b0; enable = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
`ifdef DEC_COUNTER_AUTO_RELOAD_EN
        test_auto_reload();
`else
        test_count_down();
        test_enable_gate();
        test_step_modes();
        test_load_cases();
        test_back_to_back();
`endif
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
